// File: rtl/nfu_pkg.sv
// rtl/nfu_pkg.sv - shared NFU widths, FSM state encoding and Q6.10 constants
package nfu_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_TN        = 16;

  // Q6.10 fixed-point 1.0
  localparam logic [15:0] ONE = 16'h0400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } nbout_state_e;

endpackage

// File: rtl/nbout_psum_reg.sv
// rtl/nbout_psum_reg.sv - Tn-lane partial-sum register with synchronous load/clear
module nbout_psum_reg
  import nfu_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int Tn        = DEF_TN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic [BIT_WIDTH*Tn-1:0] d_i,
  output logic [BIT_WIDTH*Tn-1:0] q_o
);

  logic [BIT_WIDTH*Tn-1:0] psum_q;
  logic [BIT_WIDTH*Tn-1:0] psum_d;

  // Clear wins over load so a drain always leaves a zero seed for the next group.
  always_comb begin
    psum_d = psum_q;
    if (clr_i) begin
      psum_d = '0;
    end else if (load_i) begin
      psum_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q <= '0;
    end else begin
      psum_q <= psum_d;
    end
  end

  assign q_o = psum_q;

endmodule

// File: rtl/nbout_accum.sv
// rtl/nbout_accum.sv - NBout partial-sum holder, tile counter and NFU-3 drain controller
module nbout_accum
  import nfu_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int Tn        = DEF_TN,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_num_tiles,
  input  logic                    i_nfu2_valid,
  output logic                    o_nfu2_ready,
  input  logic [BIT_WIDTH*Tn-1:0] i_nfu2_out,
  output logic [BIT_WIDTH*Tn-1:0] o_partial_sum,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BIT_WIDTH*Tn-1:0] o_out_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_tile_cnt
);

  nbout_state_e            state_q, state_d;
  logic [CNT_W-1:0]        tile_cnt_q, tile_cnt_d;
  logic [CNT_W-1:0]        num_tiles_q, num_tiles_d;
  logic                    done_q, done_d;
  logic                    psum_clr;
  logic                    psum_load;
  logic [BIT_WIDTH*Tn-1:0] psum;

  nbout_psum_reg #(
    .BIT_WIDTH(BIT_WIDTH),
    .Tn       (Tn)
  ) u_psum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (psum_clr),
    .load_i(psum_load),
    .d_i   (i_nfu2_out),
    .q_o   (psum)
  );

  always_comb begin
    state_d      = state_q;
    tile_cnt_d   = tile_cnt_q;
    num_tiles_d  = num_tiles_q;
    done_d       = 1'b0;
    psum_clr     = 1'b0;
    psum_load    = 1'b0;
    o_nfu2_ready = 1'b0;
    o_out_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          psum_clr    = 1'b1;
          tile_cnt_d  = '0;
          // A zero tile count still runs one tile.
          num_tiles_d = (i_num_tiles == '0) ? CNT_W'(1) : i_num_tiles;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        o_nfu2_ready = 1'b1;
        if (i_nfu2_valid) begin
          psum_load  = 1'b1;
          tile_cnt_d = tile_cnt_q + CNT_W'(1);
          if (tile_cnt_q == num_tiles_q - CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          psum_clr   = 1'b1;
          tile_cnt_d = '0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tile_cnt_q  <= '0;
      num_tiles_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_cnt_q  <= tile_cnt_d;
      num_tiles_q <= num_tiles_d;
      done_q      <= done_d;
    end
  end

  assign o_partial_sum = psum;
  assign o_out_data    = psum;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_tile_cnt    = tile_cnt_q;

endmodule

// File: tb/tb_nbout_accum.sv
// tb/tb_nbout_accum.sv - directed table-driven bench for nbout_accum
module tb_nbout_accum;

  localparam int BW = 16;
  localparam int TN = 16;
  localparam int CW = 8;
  localparam int W  = BW * TN;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          i_start      = 1'b0;
  logic [CW-1:0] i_num_tiles  = '0;
  logic          i_nfu2_valid = 1'b0;
  logic          i_out_ready  = 1'b0;
  logic          use_model    = 1'b0;
  logic [W-1:0]  nfu2_drv     = '0;
  logic [W-1:0]  nfu2_model;
  logic [W-1:0]  i_nfu2_out;
  logic          o_nfu2_ready;
  logic [W-1:0]  o_partial_sum;
  logic          o_out_valid;
  logic [W-1:0]  o_out_data;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_tile_cnt;

  int checks = 0;
  int errors = 0;

  nbout_accum #(.BIT_WIDTH(BW), .Tn(TN), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_num_tiles  (i_num_tiles),
    .i_nfu2_valid (i_nfu2_valid),
    .o_nfu2_ready (o_nfu2_ready),
    .i_nfu2_out   (i_nfu2_out),
    .o_partial_sum(o_partial_sum),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tile_cnt   (o_tile_cnt)
  );

  always #5 clk = ~clk;

  // NFU-2 stand-in: adds 1.0 to every lane of the fed-back partial sum.
  always_comb begin
    nfu2_model = '0;
    for (int l = 0; l < TN; l++) begin
      nfu2_model[l*BW +: BW] = o_partial_sum[l*BW +: BW] + nfu_pkg::ONE;
    end
  end
  assign i_nfu2_out = use_model ? nfu2_model : nfu2_drv;

  typedef struct {
    logic          st;
    logic [CW-1:0] nt;
    logic          v;
    logic          rdy;
    logic [1:0]    mode;
    logic [BW-1:0] d;
    logic          e_rdy;
    logic          e_val;
    logic          e_busy;
    logic          e_done;
    logic [CW-1:0] e_cnt;
    logic [BW-1:0] e_p;
    logic          e_inc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] lanes(input logic [BW-1:0] base, input logic inc);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < TN; l++) begin
      r[l*BW +: BW] = base + (inc ? BW'(l) : BW'(0));
    end
    return r;
  endfunction

  function automatic vec_t mkv(input logic st, input logic [CW-1:0] nt, input logic v,
                               input logic rdy, input logic [1:0] mode, input logic [BW-1:0] d,
                               input logic e_rdy, input logic e_val, input logic e_busy,
                               input logic e_done, input logic [CW-1:0] e_cnt,
                               input logic [BW-1:0] e_p, input logic e_inc);
    vec_t r;
    r.st = st; r.nt = nt; r.v = v; r.rdy = rdy; r.mode = mode; r.d = d;
    r.e_rdy = e_rdy; r.e_val = e_val; r.e_busy = e_busy; r.e_done = e_done;
    r.e_cnt = e_cnt; r.e_p = e_p; r.e_inc = e_inc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_val,
                         input logic e_busy, input logic e_done, input logic [CW-1:0] e_cnt,
                         input logic [W-1:0] e_psum);
    chk({tag, "_ready"}, W'(o_nfu2_ready), W'(e_rdy));
    chk({tag, "_valid"}, W'(o_out_valid), W'(e_val));
    chk({tag, "_busy"}, W'(o_busy), W'(e_busy));
    chk({tag, "_done"}, W'(o_done), W'(e_done));
    chk({tag, "_cnt"}, W'(o_tile_cnt), W'(e_cnt));
    chk({tag, "_psum"}, o_partial_sum, e_psum);
    chk({tag, "_odata"}, o_out_data, e_psum);
  endtask

  task automatic apply(input int k);
    vec_t v;
    v            = vecs[k];
    i_start      = v.st;
    i_num_tiles  = v.nt;
    i_nfu2_valid = v.v;
    i_out_ready  = v.rdy;
    use_model    = (v.mode == 2'd1);
    nfu2_drv     = lanes(v.d, v.mode == 2'd2);
    @(posedge clk);
    #1;
    chk_all($sformatf("v%0d", k), v.e_rdy, v.e_val, v.e_busy, v.e_done, v.e_cnt,
            lanes(v.e_p, v.e_inc));
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_num_tiles = '0; i_nfu2_valid = 1'b0; i_out_ready = 1'b0;
    use_model = 1'b0; nfu2_drv = '0;
  endtask

  initial begin
    //           st nt v  r  md d         rdy val bsy dn cnt p        inc
    // single tile
    vecs.push_back(mkv(1, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 16'h0400, 0, 1, 1, 0, 1, 16'h0400, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 16'h0400, 0, 0, 0, 1, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0));
    // four tiles through the NFU-2 model
    vecs.push_back(mkv(1, 4, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 16'h0400, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 1, 0, 1, 0, 2, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 1, 0, 1, 0, 3, 16'h0C00, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 0, 1, 1, 0, 4, 16'h1000, 0));
    // backpressure with ignored valid pulses
    vecs.push_back(mkv(0, 0, 1, 0, 0, 16'hFFFF, 0, 1, 1, 0, 4, 16'h1000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 1, 0, 4, 16'h1000, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 16'hFFFF, 0, 1, 1, 0, 4, 16'h1000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 1, 0, 4, 16'h1000, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 16'hFFFF, 0, 1, 1, 0, 4, 16'h1000, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0));
    // zero count, started in the done cycle; start in DRAIN ignored
    vecs.push_back(mkv(1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 2, 16'h1234, 0, 1, 1, 0, 1, 16'h1234, 1));
    vecs.push_back(mkv(1, 2, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0));
    // three tiles with two-cycle bubbles; start in ACCUM ignored
    vecs.push_back(mkv(1, 3, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 16'h0400, 0));
    vecs.push_back(mkv(1, 7, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 16'h0400, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 16'h0400, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 1, 0, 1, 0, 2, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 2, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 2, 16'h0800, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 16'h0000, 0, 1, 1, 0, 3, 16'h0C00, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0));
    // valid in IDLE ignored
    vecs.push_back(mkv(0, 0, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 16'h0000, 0));

    // reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      i_start      = 1'($urandom);
      i_num_tiles  = CW'($urandom);
      i_nfu2_valid = 1'($urandom);
      i_out_ready  = 1'($urandom);
      nfu2_drv     = {8{$urandom}};
      @(posedge clk);
      #1;
      chk_all($sformatf("rst%0d", c), 0, 0, 0, 0, 0, '0);
    end
    idle_inputs();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_ready", c), W'(o_nfu2_ready), W'(1'b0));
    end

    for (int k = 0; k < vecs.size(); k++) begin
      apply(k);
    end

    // async reset after 2 of 4 tiles
    idle_inputs();
    i_start = 1'b1; i_num_tiles = 4;
    @(posedge clk); #1;
    i_start = 1'b0; i_nfu2_valid = 1'b1; use_model = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_psum", o_partial_sum, lanes(16'h0800, 0));
    i_nfu2_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("arst_nodone%0d", c), W'(o_done), W'(1'b0));
      chk($sformatf("arst_idle%0d", c), W'(o_busy), W'(1'b0));
    end

    // fresh two-tile group
    i_start = 1'b1; i_num_tiles = 2;
    @(posedge clk); #1;
    chk_all("fresh_start", 1, 0, 1, 0, 0, '0);
    i_start = 1'b0; i_nfu2_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("fresh_drain", 0, 1, 1, 0, 2, lanes(16'h0800, 0));
    i_nfu2_valid = 1'b0; i_out_ready = 1'b1;
    @(posedge clk); #1;
    chk_all("fresh_done", 0, 0, 0, 1, 0, '0);
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("fresh_done_clr", W'(o_done), W'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
